// File: rtl/draw_arbiter.sv
// -----------------------------------------------------------------------------
// draw_arbiter
//
// Shares one rectangle draw engine between three requesters: brick field (0),
// ball (1) and paddle (2). The arbiter picks a winner round-robin and latches
// that requester's origin and colour. It then pulses eng_start and waits for
// eng_done, and acknowledges the requester with a one-cycle ack pulse. A
// watchdog aborts a draw whose engine never reports completion, and records
// the event in a sticky timeout_err flag.
//
// Ports
//   clk          system clock, rising edge
//   resetn       asynchronous active-low reset
//   req[2:0]     per-requester request, held until its ack
//   req_x[29:0]  per-requester origin x, requester r at [10r+9:10r]
//   req_y[29:0]  per-requester origin y, same packing
//   req_color    per-requester colour, requester r at [3r+2:3r]
//   grant[2:0]   one-hot served requester, ISSUE through ACK
//   ack[2:0]     one-cycle completion/abort pulse to the served requester
//   eng_x/eng_y  latched origin to the engine
//   eng_color    latched colour to the engine
//   eng_start    one-cycle engine start pulse
//   eng_done     one-cycle engine completion pulse
//   busy         high whenever the arbiter is not idle
//   timeout_err  sticky watchdog-abort flag
// -----------------------------------------------------------------------------
module draw_arbiter #(
  parameter logic [15:0] TIMEOUT = 16'd4095
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [2:0]  req,
  input  logic [29:0] req_x,
  input  logic [29:0] req_y,
  input  logic [8:0]  req_color,
  output logic [2:0]  grant,
  output logic [2:0]  ack,
  output logic [9:0]  eng_x,
  output logic [9:0]  eng_y,
  output logic [2:0]  eng_color,
  output logic        eng_start,
  input  logic        eng_done,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  last_q, last_d;
  logic [2:0]  grant_q, grant_d;
  logic [2:0]  ack_q, ack_d;
  logic [9:0]  eng_x_q, eng_x_d;
  logic [9:0]  eng_y_q, eng_y_d;
  logic [2:0]  eng_color_q, eng_color_d;
  logic        eng_start_q, eng_start_d;
  logic        busy_q, busy_d;
  logic        timeout_err_q, timeout_err_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  winner_s;

  // Successor of a requester index in the 0 -> 1 -> 2 -> 0 ring.
  function automatic logic [1:0] next_idx(input logic [1:0] i);
    logic [1:0] n;
    case (i)
      2'd0:    n = 2'd1;
      2'd1:    n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

  // Round-robin pick: search starts one past the last served requester.
  // The previously served requester is considered last, so it only wins
  // again when nobody else is pending. Callers qualify with |req.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] c1;
    logic [1:0] c2;
    logic [1:0] w;
    c1 = next_idx(last);
    c2 = next_idx(c1);
    if (r[c1]) begin
      w = c1;
    end else if (r[c2]) begin
      w = c2;
    end else begin
      w = next_idx(c2);
    end
    return w;
  endfunction

  function automatic logic [2:0] idx_to_onehot(input logic [1:0] i);
    logic [2:0] o;
    case (i)
      2'd0:    o = 3'b001;
      2'd1:    o = 3'b010;
      default: o = 3'b100;
    endcase
    return o;
  endfunction

  function automatic logic [1:0] onehot_to_idx(input logic [2:0] g);
    logic [1:0] i;
    case (g)
      3'b010:  i = 2'd1;
      3'b100:  i = 2'd2;
      default: i = 2'd0;
    endcase
    return i;
  endfunction

  assign winner_s = rr_pick(req, last_q);

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    grant_d       = grant_q;
    ack_d         = 3'b000;
    eng_x_d       = eng_x_q;
    eng_y_d       = eng_y_q;
    eng_color_d   = eng_color_q;
    eng_start_d   = 1'b0;
    timeout_err_d = timeout_err_q;
    cnt_d         = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (req != 3'b000) begin
          state_d     = S_ISSUE;
          grant_d     = idx_to_onehot(winner_s);
          // Start is registered, so it is raised here to appear in ISSUE.
          eng_start_d = 1'b1;
          case (winner_s)
            2'd0: begin
              eng_x_d     = req_x[9:0];
              eng_y_d     = req_y[9:0];
              eng_color_d = req_color[2:0];
            end
            2'd1: begin
              eng_x_d     = req_x[19:10];
              eng_y_d     = req_y[19:10];
              eng_color_d = req_color[5:3];
            end
            default: begin
              eng_x_d     = req_x[29:20];
              eng_y_d     = req_y[29:20];
              eng_color_d = req_color[8:6];
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ISSUE: begin
        // eng_done is deliberately not looked at here.
        cnt_d   = 16'd0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // Done takes priority over the watchdog when both coincide.
        if (eng_done) begin
          state_d = S_ACK;
          ack_d   = grant_q;
        end else if (cnt_q == (TIMEOUT - 16'd1)) begin
          state_d       = S_ACK;
          ack_d         = grant_q;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_ACK: begin
        last_d  = onehot_to_idx(grant_q);
        grant_d = 3'b000;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        grant_d = 3'b000;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered-output flops.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      last_q        <= 2'd2;
      grant_q       <= 3'b000;
      ack_q         <= 3'b000;
      eng_x_q       <= 10'd0;
      eng_y_q       <= 10'd0;
      eng_color_q   <= 3'b000;
      eng_start_q   <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      cnt_q         <= 16'd0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      grant_q       <= grant_d;
      ack_q         <= ack_d;
      eng_x_q       <= eng_x_d;
      eng_y_q       <= eng_y_d;
      eng_color_q   <= eng_color_d;
      eng_start_q   <= eng_start_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      cnt_q         <= cnt_d;
    end
  end

  assign grant       = grant_q;
  assign ack         = ack_q;
  assign eng_x       = eng_x_q;
  assign eng_y       = eng_y_q;
  assign eng_color   = eng_color_q;
  assign eng_start   = eng_start_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: doc/draw_arbiter.md
# draw_arbiter

Shares the single rectangle draw engine, and through it the VGA write port, between three requesters: brick field, ball and paddle. Each requester posts a rectangle origin and colour. The arbiter grants round-robin, launches the engine with a start pulse and waits for its done pulse. It then acknowledges the requester, and a watchdog recovers from an engine that never finishes.

## Interface
- TIMEOUT, 16'd4095: cycles to wait in WAIT for eng_done before aborting the draw.
- clk  in  1  system clock; all state changes on rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- req  in  3  request per requester (bit 0 brick, 1 ball, 2 paddle); held high until its ack.
- req_x  in  30  origin x per requester; requester r at [10r+9:10r].
- req_y  in  30  origin y per requester; same packing.
- req_color  in  9  colour per requester; requester r at [3r+2:3r].
- grant  out  3  one-hot; high for the served requester from ISSUE through ACK inclusive.
- ack  out  3  one-cycle pulse on the served requester's bit when its draw is finished or aborted.
- eng_x, eng_y  out  10 each  latched origin to the engine; stable from ISSUE until the next grant.
- eng_color  out  3  latched colour to the engine; same stability.
- eng_start  out  1  one-cycle start pulse to the engine.
- eng_done  in  1  one-cycle completion pulse from the engine.
- busy  out  1  high whenever state is not IDLE.
- timeout_err  out  1  sticky; set on any watchdog abort, cleared only by reset.

## Operation
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - If req is nonzero, select the winner by round-robin.
  - Search order starts at last+1 mod 3, then wraps.
  - Latch the winner's x, y and colour into eng_x/eng_y/eng_color.
  - Record the winner in the grant register, then go to ISSUE.
  - If req is zero, stay in IDLE.
- ISSUE: eng_start=1 for this single cycle; clear the watchdog counter; go to WAIT.
- WAIT:
  - If eng_done=1, go to ACK.
  - Otherwise, if the counter equals TIMEOUT-1, set timeout_err and go to ACK.
  - Otherwise, increment the counter.
- ACK: ack[g]=1 for this cycle; set last<=g; go to IDLE, where grant clears.
- eng_done is ignored outside WAIT, including in ISSUE: an engine completing in zero cycles is illegal.
- The latched eng_x/eng_y/eng_color do not change if the requester alters its inputs or drops req mid-draw. The draw still completes and the ack still pulses.
- A requester holding req high after its ack is eligible again. Round-robin guarantees that every other pending requester is served first.
- Widths: the watchdog counter is 16 bits; last is 2 bits holding only 0..2.

## Timing
- Reset values (asynchronous, immediate on resetn low):
  - state IDLE; last=2, so requester 0 wins first.
  - grant=0, ack=0, eng_start=0, busy=0, timeout_err=0.
  - eng_x=0, eng_y=0, eng_color=0; counter=0.
- Reset mid-draw returns to IDLE immediately. No ack is issued. The engine is reset by its own resetn.
- Per-draw timing:
  - req sampled high at edge k in IDLE → ISSUE in cycle k+1, with eng_start and grant high.
  - eng_done in cycle m (WAIT) → ack in cycle m+1.
  - IDLE in cycle m+2.
- Back-to-back: the next eng_start comes at cycle m+3 at the earliest, so each draw costs 3 cycles of overhead plus the engine time.
- Timeout: with eng_done never asserted, ack comes exactly TIMEOUT+1 cycles after eng_start. timeout_err rises in the ACK cycle.
- A simultaneous eng_done and counter==TIMEOUT-1 counts as done; timeout_err is not set.

## Test plan
- Reset, then req=3'b001 with x=40, y=20, colour 3'b111; engine done 12 cycles after start → eng_start one cycle after the req edge, eng_x=40, eng_y=20, eng_color=3'b111, ack[0] one cycle after done, busy low afterwards.
- req=3'b111 held high continuously → grants in order 0,1,2,0,1,2; exactly one eng_start per ack, and never two grant bits high at once.
- Serving requester 1 with x=100; requester changes x to 200 and drops req mid-draw → eng_x stays 100 until ACK, ack[1] still pulses.
- TIMEOUT=8, engine never done → ack 9 cycles after eng_start, timeout_err=1 and stays 1 across later successful draws.
- resetn low during WAIT → all outputs zero immediately. Then req=3'b110 → requester 1 served first.
- Spurious eng_done pulses in IDLE and in ISSUE → no ack, and no state change other than ISSUE→WAIT.
